mano_control_unit: RTL and testbench
====================================

Name: mano_control_unit

Overview:
- Timing-and-control sequencer for the 8-bit Mano basic computer datapath: accumulator (AC), data register (DR), instruction register (IR), 4-bit program counter (PC) and address register (AR), shared bus, 16-word memory.
- Owns the sequence counter (SC), the T/D decode and the I flip-flop.
- Drives every bus select and register load/increment/clear enable that fetches, decodes and executes one instruction.
- Sits beside the datapath at top level and replaces hand-driven select/enable wiring.

Parameters:
- DATA_W, 8, datapath and IR width (encoding below is fixed for 8).
- ADDR_W, 4, address field width, IR[3:0].

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ir_in  in  8  current IR contents: I=IR[7], opcode=IR[6:4], addr=IR[3:0].
- dr_zero  in  1  DR==0 from datapath, sampled only at T6.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM.
- ar_ld, ar_inc  out  1  AR load from bus / increment.
- pc_ld, pc_inc  out  1  PC load from bus / increment.
- dr_ld, dr_inc  out  1  DR load / increment.
- ac_ld, ac_clr, ac_inc  out  1  AC load from ALU / clear / increment.
- alu_sel  out  2  0 AND, 1 ADD, 2 PASS_DR, 3 NOT_AC.
- e_ld  out  1  E <- ALU carry.
- ir_ld  out  1  IR load from bus.
- mem_wr  out  1  M[AR] <- bus.
- sc_out  out  3  sequence counter value.
- timer  out  8  one-hot T0..T7 decode of SC.
- D  out  8  one-hot opcode decode of ir_in[6:4].
- i_flag  out  1  I flip-flop.
- halted  out  1  machine stopped.

Behaviour:
State and outputs:
- State registers: sc[2:0], i_ff, halted. All update on rising CLK.
- Control outputs are combinational from state and ir_in; an action is asserted during Tn and takes effect at the edge ending Tn.
- RST high at an edge: sc=0, i_ff=0, halted=0. Applies mid-instruction; any partial instruction is abandoned.
- While RST is high, all enables are forced to 0, bus_sel=0 and timer=0x01.
- Unused enables are 0; bus_sel=0 when no transfer.
- SC increments each cycle; it clears to 0 on the last step of every instruction and never wraps through T7.

Fetch and decode:
- T0: bus_sel=2, ar_ld.
- T1: bus_sel=7, ir_ld, pc_inc.
- T2: bus_sel=5, ar_ld (AR <- IR[3:0]); i_ff <- ir_in[7].
- T3, D7 & ~I: register-reference; one cycle, then SC cleared.
- T3, D7 & I: I/O is unsupported; NOP, SC cleared.
- T3, ~D7 & I: bus_sel=7, ar_ld (indirect).
- T3, ~D7 & ~I: idle.

Execute (T4 onward):
- AND/ADD/LDA (D0/D1/D2): T4 bus_sel=7, dr_ld; T5 ac_ld with alu_sel 0/1/2 (ADD also e_ld); SC clear.
- STA (D3): T4 bus_sel=4, mem_wr; SC clear.
- BUN (D4): T4 bus_sel=1, pc_ld; SC clear.
- BSA (D5): T4 bus_sel=2, mem_wr, ar_inc; T5 bus_sel=1, pc_ld; SC clear.
- ISZ (D6): T4 bus_sel=7, dr_ld; T5 dr_inc; T6 bus_sel=3, mem_wr, pc_inc if dr_zero; SC clear.

Register reference, IR[3:0] bit-wise, all at T3:
- bit3 CLA: ac_clr.
- bit2 CMA: ac_ld, alu_sel=3.
- bit1 INC: ac_inc.
- bit0 HLT: halted <- 1.
- CLA set suppresses CMA and INC.
- CMA and INC together: CMA wins.
- HLT combines freely with the others.
- 0x70 is a NOP.

Halt:
- SC held at 0, all enables 0.
- Remains halted until RST.

Decomposition:
- Shared package mano_pkg holds bus_sel codes, alu_sel codes, opcode constants (AND..ISZ, REGREF=7) and register-reference bit positions; the datapath mux/ALU uses the same package.
- One sub-module is natural: mano_seq_counter (3-bit SC with clear/increment plus the one-hot timer decode).
- D decode and the control equations stay in the top.

Test Plan:
- RST high 2 cycles mid-T4, release, ir_in=0x25 (LDA 5) -> after RST sc=0, timer=0x01; T0 bus_sel=2 ar_ld=1; T1 bus_sel=7 ir_ld=1 pc_inc=1; T4 dr_ld=1; T5 ac_ld=1 alu_sel=2; next cycle sc=0.
- ir_in=0xA3 (indirect LDA) -> i_flag=1 after T2; T3 bus_sel=7 ar_ld=1; total 6 cycles back to T0.
- ir_in=0x1x (ADD) -> T5 ac_ld=1 alu_sel=1 e_ld=1.
- ir_in=0x58 (BSA 8) -> T4 mem_wr=1 bus_sel=2 ar_inc=1; T5 pc_ld=1 bus_sel=1.
- ir_in=0x6x (ISZ), dr_zero=1 at T6 -> T6 mem_wr=1 bus_sel=3 pc_inc=1; with dr_zero=0 -> pc_inc=0; sc reaches 6 then 0.
- ir_in=0x7A (CLA+INC) -> T3 ac_clr=1, ac_inc=0.
- ir_in=0x71 (HLT) -> halted=1 after T3; sc stays 0 and all enables 0 for 20 cycles; RST clears halted.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic computer: bus source codes, ALU
// operations, opcodes, register-reference bit positions and timing steps.
// The control unit and the datapath mux/ALU both import this package.
package mano_pkg;

    // Bus source select codes (code 6 is unused)
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // ALU operation select codes
    localparam logic [1:0] ALU_AND     = 2'd0;
    localparam logic [1:0] ALU_ADD     = 2'd1;
    localparam logic [1:0] ALU_PASS_DR = 2'd2;
    localparam logic [1:0] ALU_NOT_AC  = 2'd3;

    // Opcodes held in IR[6:4]
    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REGREF = 3'd7;

    // Register-reference bit positions within IR[3:0]
    localparam int RR_CLA = 3;
    localparam int RR_CMA = 2;
    localparam int RR_INC = 1;
    localparam int RR_HLT = 0;

    // Timing steps of the sequence counter; T7 is never reached
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic [2:0] bus_sel;
        logic [1:0] alu_sel;
        logic       ar_ld;
        logic       ar_inc;
        logic       pc_ld;
        logic       pc_inc;
        logic       dr_ld;
        logic       dr_inc;
        logic       ac_ld;
        logic       ac_clr;
        logic       ac_inc;
        logic       e_ld;
        logic       ir_ld;
        logic       mem_wr;
    } ctrl_t;

    // 3-to-8 one-hot decode, shared by the T and D decoders
    function automatic logic [7:0] onehot8(input logic [2:0] v);
        return 8'b0000_0001 << v;
    endfunction

endpackage

// File: rtl/mano_control_unit_if.sv
// Control/status bundle between the Mano control unit and its datapath.
// master = control unit, slave = datapath.
interface mano_control_unit_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] ir_in;
    logic              dr_zero;
    logic [2:0]        bus_sel;
    logic              ar_ld;
    logic              ar_inc;
    logic              pc_ld;
    logic              pc_inc;
    logic              dr_ld;
    logic              dr_inc;
    logic              ac_ld;
    logic              ac_clr;
    logic              ac_inc;
    logic [1:0]        alu_sel;
    logic              e_ld;
    logic              ir_ld;
    logic              mem_wr;
    logic [2:0]        sc_out;
    logic [7:0]        timer;
    logic [7:0]        D;
    logic              i_flag;
    logic              halted;

    modport master (
        input  ir_in, dr_zero,
        output bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
               ac_ld, ac_clr, ac_inc, alu_sel, e_ld, ir_ld, mem_wr,
               sc_out, timer, D, i_flag, halted
    );

    modport slave (
        output ir_in, dr_zero,
        input  bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
               ac_ld, ac_clr, ac_inc, alu_sel, e_ld, ir_ld, mem_wr,
               sc_out, timer, D, i_flag, halted
    );
endinterface

// File: rtl/mano_seq_counter.sv
// 3-bit sequence counter with clear/increment and its one-hot T decode.
// Clear has priority over increment; reset forces the decode to T0.
module mano_seq_counter
    import mano_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] sc,
    output logic [7:0] timer
);

    logic [2:0] sc_r;

    // Sequence counter: reset/clear to T0, otherwise step when enabled
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sc_r <= 3'd0;
        end else if (inc) begin
            sc_r <= sc_r + 3'd1;
        end else begin
            sc_r <= sc_r;
        end
    end

    // One-hot timing decode, pinned to T0 while reset is held
    always_comb begin
        if (rst) begin
            timer = 8'h01;
        end else begin
            timer = onehot8(sc_r);
        end
    end

    assign sc = sc_r;

endmodule

// File: rtl/mano_control_unit.sv
// Timing-and-control sequencer for the 8-bit Mano basic computer.
// Decodes SC and IR into bus selects and register enables for fetch,
// decode and execute; owns the I flip-flop and the halt flag.
module mano_control_unit
    import mano_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
)
(
    input  logic                CLK,
    input  logic                RST,
    mano_control_unit_if.master cu
);

    logic [2:0]        op_s;
    logic              i_bit_s;
    logic [ADDR_W-1:0] rr_s;
    logic [7:0]        d_s;
    logic [2:0]        sc_s;
    logic [7:0]        timer_s;
    logic              sc_clr_s;
    logic              sc_inc_s;
    logic              i_ld_s;
    logic              hlt_set_s;
    ctrl_t             ctrl_s;
    logic              i_ff_r;
    logic              halted_r;

    assign i_bit_s = cu.ir_in[DATA_W-1];
    assign op_s    = cu.ir_in[DATA_W-2 -: 3];
    assign rr_s    = cu.ir_in[ADDR_W-1:0];
    assign d_s     = onehot8(op_s);

    mano_seq_counter u_sc (
        .clk   (CLK),
        .rst   (RST),
        .clr   (sc_clr_s),
        .inc   (sc_inc_s),
        .sc    (sc_s),
        .timer (timer_s)
    );

    // Control equations: one micro-operation set per timing step
    always_comb begin
        ctrl_s    = '0;
        sc_clr_s  = 1'b0;
        sc_inc_s  = 1'b0;
        i_ld_s    = 1'b0;
        hlt_set_s = 1'b0;
        if (RST) begin
            sc_clr_s = 1'b1;
        end else if (halted_r) begin
            // Stopped machine: park SC at T0 and drive nothing
            sc_clr_s = 1'b1;
        end else begin
            sc_inc_s = 1'b1;
            case (sc_s)
                T0: begin
                    ctrl_s.bus_sel = BUS_PC;
                    ctrl_s.ar_ld   = 1'b1;
                end
                T1: begin
                    ctrl_s.bus_sel = BUS_MEM;
                    ctrl_s.ir_ld   = 1'b1;
                    ctrl_s.pc_inc  = 1'b1;
                end
                T2: begin
                    ctrl_s.bus_sel = BUS_IR;
                    ctrl_s.ar_ld   = 1'b1;
                    i_ld_s         = 1'b1;
                end
                T3: begin
                    if (d_s[OP_REGREF]) begin
                        // Register reference or (unsupported) I/O ends here
                        sc_clr_s = 1'b1;
                        if (!i_ff_r) begin
                            if (rr_s[RR_CLA]) begin
                                ctrl_s.ac_clr = 1'b1;
                            end else if (rr_s[RR_CMA]) begin
                                ctrl_s.ac_ld   = 1'b1;
                                ctrl_s.alu_sel = ALU_NOT_AC;
                            end else if (rr_s[RR_INC]) begin
                                ctrl_s.ac_inc = 1'b1;
                            end else begin
                                ctrl_s.ac_inc = 1'b0;
                            end
                            hlt_set_s = rr_s[RR_HLT];
                        end else begin
                            hlt_set_s = 1'b0;
                        end
                    end else if (i_ff_r) begin
                        // Indirect: AR <- M[AR]
                        ctrl_s.bus_sel = BUS_MEM;
                        ctrl_s.ar_ld   = 1'b1;
                    end else begin
                        ctrl_s.ar_ld = 1'b0;
                    end
                end
                T4: begin
                    case (op_s)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            ctrl_s.bus_sel = BUS_MEM;
                            ctrl_s.dr_ld   = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_s.bus_sel = BUS_AC;
                            ctrl_s.mem_wr  = 1'b1;
                            sc_clr_s       = 1'b1;
                        end
                        OP_BUN: begin
                            ctrl_s.bus_sel = BUS_AR;
                            ctrl_s.pc_ld   = 1'b1;
                            sc_clr_s       = 1'b1;
                        end
                        OP_BSA: begin
                            ctrl_s.bus_sel = BUS_PC;
                            ctrl_s.mem_wr  = 1'b1;
                            ctrl_s.ar_inc  = 1'b1;
                        end
                        default: sc_clr_s = 1'b1;
                    endcase
                end
                T5: begin
                    case (op_s)
                        OP_AND: begin
                            ctrl_s.ac_ld   = 1'b1;
                            ctrl_s.alu_sel = ALU_AND;
                            sc_clr_s       = 1'b1;
                        end
                        OP_ADD: begin
                            ctrl_s.ac_ld   = 1'b1;
                            ctrl_s.alu_sel = ALU_ADD;
                            ctrl_s.e_ld    = 1'b1;
                            sc_clr_s       = 1'b1;
                        end
                        OP_LDA: begin
                            ctrl_s.ac_ld   = 1'b1;
                            ctrl_s.alu_sel = ALU_PASS_DR;
                            sc_clr_s       = 1'b1;
                        end
                        OP_BSA: begin
                            ctrl_s.bus_sel = BUS_AR;
                            ctrl_s.pc_ld   = 1'b1;
                            sc_clr_s       = 1'b1;
                        end
                        OP_ISZ: begin
                            ctrl_s.dr_inc = 1'b1;
                        end
                        default: sc_clr_s = 1'b1;
                    endcase
                end
                T6: begin
                    // Only ISZ reaches T6: write back and skip if DR wrapped
                    if (op_s == OP_ISZ) begin
                        ctrl_s.bus_sel = BUS_DR;
                        ctrl_s.mem_wr  = 1'b1;
                        ctrl_s.pc_inc  = cu.dr_zero;
                    end else begin
                        ctrl_s.mem_wr = 1'b0;
                    end
                    sc_clr_s = 1'b1;
                end
                default: sc_clr_s = 1'b1;
            endcase
        end
    end

    // I flip-flop and halt flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            i_ff_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            if (i_ld_s) begin
                i_ff_r <= i_bit_s;
            end
            if (hlt_set_s) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign cu.bus_sel = ctrl_s.bus_sel;
    assign cu.alu_sel = ctrl_s.alu_sel;
    assign cu.ar_ld   = ctrl_s.ar_ld;
    assign cu.ar_inc  = ctrl_s.ar_inc;
    assign cu.pc_ld   = ctrl_s.pc_ld;
    assign cu.pc_inc  = ctrl_s.pc_inc;
    assign cu.dr_ld   = ctrl_s.dr_ld;
    assign cu.dr_inc  = ctrl_s.dr_inc;
    assign cu.ac_ld   = ctrl_s.ac_ld;
    assign cu.ac_clr  = ctrl_s.ac_clr;
    assign cu.ac_inc  = ctrl_s.ac_inc;
    assign cu.e_ld    = ctrl_s.e_ld;
    assign cu.ir_ld   = ctrl_s.ir_ld;
    assign cu.mem_wr  = ctrl_s.mem_wr;
    assign cu.sc_out  = sc_s;
    assign cu.timer   = timer_s;
    assign cu.D       = d_s;
    assign cu.i_flag  = i_ff_r;
    assign cu.halted  = halted_r;

endmodule

// File: tb/tb_mano_control_unit.sv
// Bench for mano_control_unit: a table-driven instruction model checked
// against the DUT every cycle, plus hand-computed spot checks.
module tb_mano_control_unit;

    typedef struct packed {
        logic [2:0] bus;
        logic [1:0] alu;
        logic ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
        logic ac_ld, ac_clr, ac_inc, e_ld, ir_ld, mem_wr;
    } cw_t;

    logic CLK = 1'b0;
    logic RST;
    logic chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    mano_control_unit_if #(.DATA_W(8)) cu ();

    mano_control_unit #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .cu  (cu)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    cw_t fetch_tab [0:2];
    cw_t exec_tab  [0:6][0:2];   // opcode x (T4..T6)
    int  last_tab  [0:7];        // last timing step of each opcode
    int   m_t;
    logic m_i, m_h;

    initial begin
        cw_t c;
        for (int o = 0; o < 7; o++)
            for (int s = 0; s < 3; s++) exec_tab[o][s] = '0;
        c = '0; c.bus = 3'd2; c.ar_ld = 1'b1;                   fetch_tab[0] = c;
        c = '0; c.bus = 3'd7; c.ir_ld = 1'b1; c.pc_inc = 1'b1;  fetch_tab[1] = c;
        c = '0; c.bus = 3'd5; c.ar_ld = 1'b1;                   fetch_tab[2] = c;
        // memory-reference: read operand into DR at T4
        c = '0; c.bus = 3'd7; c.dr_ld = 1'b1;
        exec_tab[0][0] = c; exec_tab[1][0] = c; exec_tab[2][0] = c; exec_tab[6][0] = c;
        c = '0; c.ac_ld = 1'b1; c.alu = 2'd0;                   exec_tab[0][1] = c;
        c = '0; c.ac_ld = 1'b1; c.alu = 2'd1; c.e_ld = 1'b1;    exec_tab[1][1] = c;
        c = '0; c.ac_ld = 1'b1; c.alu = 2'd2;                   exec_tab[2][1] = c;
        c = '0; c.bus = 3'd4; c.mem_wr = 1'b1;                  exec_tab[3][0] = c;
        c = '0; c.bus = 3'd1; c.pc_ld = 1'b1;                   exec_tab[4][0] = c;
        c = '0; c.bus = 3'd2; c.mem_wr = 1'b1; c.ar_inc = 1'b1; exec_tab[5][0] = c;
        c = '0; c.bus = 3'd1; c.pc_ld = 1'b1;                   exec_tab[5][1] = c;
        c = '0; c.dr_inc = 1'b1;                                exec_tab[6][1] = c;
        c = '0; c.bus = 3'd3; c.mem_wr = 1'b1;                  exec_tab[6][2] = c;
        last_tab[0] = 5; last_tab[1] = 5; last_tab[2] = 5; last_tab[3] = 4;
        last_tab[4] = 4; last_tab[5] = 5; last_tab[6] = 6; last_tab[7] = 3;
    end

    function automatic cw_t model_cw(input int t, input logic [7:0] ir, input logic i,
                                     input logic h, input logic rst, input logic dz);
        cw_t c = '0;
        int op = int'(ir[6:4]);
        if (rst || h) return c;
        if (t <= 2) return fetch_tab[t];
        if (t == 3) begin
            if (op == 7) begin
                if (!i) begin
                    if (ir[3]) c.ac_clr = 1'b1;
                    else if (ir[2]) begin c.ac_ld = 1'b1; c.alu = 2'd3; end
                    else if (ir[1]) c.ac_inc = 1'b1;
                end
            end else if (i) begin
                c.bus = 3'd7; c.ar_ld = 1'b1;
            end
            return c;
        end
        if (op == 7 || t > 6) return c;
        c = exec_tab[op][t-4];
        if (op == 6 && t == 6) c.pc_inc = dz;
        return c;
    endfunction

    // Model state advance on each rising edge
    always @(posedge CLK) begin
        if (RST) begin
            m_t <= 0; m_i <= 1'b0; m_h <= 1'b0;
        end else if (m_h) begin
            m_t <= 0;
        end else begin
            if (m_t == 2) m_i <= cu.ir_in[7];
            if (m_t == 3 && cu.ir_in[6:4] == 3'd7 && !m_i && cu.ir_in[0]) m_h <= 1'b1;
            m_t <= (m_t == last_tab[cu.ir_in[6:4]]) ? 0 : m_t + 1;
        end
    end

    function automatic cw_t dut_cw();
        return {cu.bus_sel, cu.alu_sel, cu.ar_ld, cu.ar_inc, cu.pc_ld, cu.pc_inc,
                cu.dr_ld, cu.dr_inc, cu.ac_ld, cu.ac_clr, cu.ac_inc, cu.e_ld,
                cu.ir_ld, cu.mem_wr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ctrl",   32'(dut_cw()), 32'(model_cw(m_t, cu.ir_in, m_i, m_h, RST, cu.dr_zero)));
            chk("sc_out", 32'(cu.sc_out), m_t);
            chk("timer",  32'(cu.timer),  RST ? 32'h01 : (32'h01 << m_t));
            chk("D",      32'(cu.D),      32'h01 << cu.ir_in[6:4]);
            chk("i_flag", 32'(cu.i_flag), 32'(m_i));
            chk("halted", 32'(cu.halted), 32'(m_h));
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [7:0] ir, input int exp_len);
        int n;
        cu.ir_in = ir;
        n = 0;
        do begin
            nxt();
            n++;
        end while (cu.sc_out != 3'd0 && n < 20);
        chk($sformatf("len_%02h", ir), n, exp_len);
    endtask

    logic [7:0] mix_ir  [0:6] = '{8'h37, 8'h49, 8'h02, 8'hF1, 8'h76, 8'h70, 8'hC4};
    int         mix_len [0:6] = '{5, 5, 6, 4, 4, 4, 5};

    initial begin
        int n;
        RST = 1'b1; cu.ir_in = 8'h00; cu.dr_zero = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        chk("rst_sc", 32'(cu.sc_out), 0);
        chk("rst_timer", 32'(cu.timer), 32'h01);
        chk("rst_bus", 32'(cu.bus_sel), 0);

        // LDA 5, interrupted by reset in T4
        cu.ir_in = 8'h25; RST = 1'b0; #1;
        chk("t0_bus", 32'(cu.bus_sel), 2); chk("t0_ar_ld", 32'(cu.ar_ld), 1);
        nxt();
        chk("t1_bus", 32'(cu.bus_sel), 7); chk("t1_ir_ld", 32'(cu.ir_ld), 1);
        chk("t1_pc_inc", 32'(cu.pc_inc), 1);
        nxt(); nxt(); nxt();
        chk("mid_sc", 32'(cu.sc_out), 4); chk("mid_dr_ld", 32'(cu.dr_ld), 1);
        RST = 1'b1; #1;
        chk("rsthi_bus", 32'(cu.bus_sel), 0); chk("rsthi_dr_ld", 32'(cu.dr_ld), 0);
        chk("rsthi_timer", 32'(cu.timer), 32'h01);
        nxt(); nxt();
        RST = 1'b0; #1;
        chk("after_rst_sc", 32'(cu.sc_out), 0); chk("after_rst_timer", 32'(cu.timer), 32'h01);
        chk("lda_t0_bus", 32'(cu.bus_sel), 2); chk("lda_t0_ar_ld", 32'(cu.ar_ld), 1);
        nxt(); nxt(); nxt(); nxt();
        chk("lda_t4_dr_ld", 32'(cu.dr_ld), 1);
        nxt();
        chk("lda_t5_ac_ld", 32'(cu.ac_ld), 1); chk("lda_t5_alu", 32'(cu.alu_sel), 2);
        nxt();
        chk("lda_end_sc", 32'(cu.sc_out), 0);

        // Indirect LDA
        cu.ir_in = 8'hA3;
        nxt(); nxt(); nxt();
        chk("ind_sc", 32'(cu.sc_out), 3); chk("ind_i_flag", 32'(cu.i_flag), 1);
        chk("ind_bus", 32'(cu.bus_sel), 7); chk("ind_ar_ld", 32'(cu.ar_ld), 1);
        n = 3;
        while (cu.sc_out != 3'd0 && n < 20) begin nxt(); n++; end
        chk("ind_len", n, 6);

        // ADD
        cu.ir_in = 8'h15;
        repeat (5) nxt();
        chk("add_ac_ld", 32'(cu.ac_ld), 1); chk("add_alu", 32'(cu.alu_sel), 1);
        chk("add_e_ld", 32'(cu.e_ld), 1);
        nxt();

        // BSA 8
        cu.ir_in = 8'h58;
        repeat (4) nxt();
        chk("bsa_t4_wr", 32'(cu.mem_wr), 1); chk("bsa_t4_bus", 32'(cu.bus_sel), 2);
        chk("bsa_t4_ar_inc", 32'(cu.ar_inc), 1);
        nxt();
        chk("bsa_t5_pc_ld", 32'(cu.pc_ld), 1); chk("bsa_t5_bus", 32'(cu.bus_sel), 1);
        nxt();

        // ISZ, DR becomes zero then nonzero
        cu.ir_in = 8'h63; cu.dr_zero = 1'b1;
        repeat (6) nxt();
        chk("isz_t6_wr", 32'(cu.mem_wr), 1); chk("isz_t6_bus", 32'(cu.bus_sel), 3);
        chk("isz_t6_pc_inc", 32'(cu.pc_inc), 1);
        nxt();
        cu.dr_zero = 1'b0;
        repeat (6) nxt();
        chk("isz2_sc", 32'(cu.sc_out), 6); chk("isz2_pc_inc", 32'(cu.pc_inc), 0);
        chk("isz2_wr", 32'(cu.mem_wr), 1);
        nxt();
        chk("isz2_end_sc", 32'(cu.sc_out), 0);

        // Mixed instructions checked by the model and by length
        for (int k = 0; k < 7; k++) run_instr(mix_ir[k], mix_len[k]);

        // CLA+INC: CLA wins
        cu.ir_in = 8'h7A;
        repeat (3) nxt();
        chk("cla_clr", 32'(cu.ac_clr), 1); chk("cla_inc", 32'(cu.ac_inc), 0);
        nxt();

        // HLT
        cu.ir_in = 8'h71;
        repeat (3) nxt();
        chk("hlt_t3_halted", 32'(cu.halted), 0);
        nxt();
        chk("hlt_halted", 32'(cu.halted), 1);
        for (int k = 0; k < 20; k++) begin
            chk("hlt_sc", 32'(cu.sc_out), 0);
            chk("hlt_quiet", 32'(dut_cw()), 0);
            nxt();
        end
        RST = 1'b1;
        nxt();
        RST = 1'b0; #1;
        chk("unhalt", 32'(cu.halted), 0); chk("unhalt_bus", 32'(cu.bus_sel), 2);
        repeat (3) nxt();

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 reached");
        $fatal(1, "watchdog");
    end

endmodule
